// File: rtl/rv32i_instr_fetch.sv
// rv32i_instr_fetch: instruction-fetch stage of the RV32I single-cycle core.
// Holds the fetch PC and a word-addressed instruction memory, and presents one
// registered instruction per cycle (with its PC) to the decoder. Supports stall,
// redirect and halt on ebreak or on an out-of-range fetch PC.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               leave IDLE/HALT and begin fetching at RESET_PC
//   stall               hold PC and outputs
//   redirect,
//   redirect_pc         take redirect_pc (word-aligned) as the next fetch PC
//   ld_en, ld_addr,
//   ld_data             instruction-memory preload (IDLE/HALT only)
//   pc, pc_plus4        PC of instr and its link address
//   instr, instr_valid  fetched instruction and its valid flag
//   halted, err         in HALT; halt caused by out-of-range PC
//   fetch_count         valid instructions issued since start (saturating)
module rv32i_instr_fetch #(
  parameter int unsigned ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic              halted,
  output logic              err,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam int unsigned Depth  = 1 << ADDR_W;
  localparam logic [31:0] Nop    = 32'h0000_0013;
  localparam logic [31:0] Ebreak = 32'h0010_0073;

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pc_plus4_q, pc_plus4_d;
  logic [31:0]      instr_q, instr_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0]      mem [Depth];
  logic [31:0]      mem_rdata;
  logic             mem_we;
  logic             in_range;

  assign mem_rdata = mem[fetch_pc_q[ADDR_W+1:2]];
  // Any set bit above the memory's byte range means the PC points past the end.
  assign in_range  = (fetch_pc_q[31:ADDR_W+2] == '0);
  assign mem_we    = ld_en && (state_q != StRun);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    err_d      = err_q;
    cnt_d      = cnt_q;

    case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        if (start) begin
          fetch_pc_d = RESET_PC;
          cnt_d      = '0;
          state_d    = StRun;
        end
      end

      StRun: begin
        if (valid_q && (instr_q == Ebreak)) begin
          // The ebreak has been issued; halt regardless of stall/redirect.
          valid_d = 1'b0;
          state_d = StHalt;
        end else if (redirect) begin
          fetch_pc_d = redirect_pc & ~32'd3;
          valid_d    = 1'b0;
        end else if (!stall) begin
          if (!in_range) begin
            err_d   = 1'b1;
            valid_d = 1'b0;
            state_d = StHalt;
          end else begin
            instr_d    = mem_rdata;
            pc_d       = fetch_pc_q;
            pc_plus4_d = fetch_pc_q + 32'd4;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          end
        end
      end

      StHalt: begin
        valid_d = 1'b0;
        if (start) begin
          err_d      = 1'b0;
          fetch_pc_d = RESET_PC;
          cnt_d      = '0;
          state_d    = StRun;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      instr_q    <= Nop;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ld_addr] <= ld_data;
  end

  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == StHalt);
  assign err         = err_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_rv32i_instr_fetch.sv
// Testbench for rv32i_instr_fetch: directed scenarios plus randomized traffic,
// all checked against a behavioural reference model of the fetch stage.
module tb_rv32i_instr_fetch;

  localparam int          AW     = 8;
  localparam int          DEPTH  = 1 << AW;
  localparam int          CW     = 5;
  localparam int          CMAX   = (1 << CW) - 1;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stall, redirect, ld_en;
  logic [31:0]   redirect_pc, ld_data;
  logic [AW-1:0] ld_addr;
  logic [31:0]   pc, pc_plus4, instr;
  logic          instr_valid, halted, err;
  logic [CW-1:0] fetch_count;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: mode 0 idle, 1 running, 2 halted.
  int          m_mode;
  logic [31:0] m_fpc, m_pc, m_pc4, m_instr;
  logic        m_valid, m_err;
  int          m_cnt;
  logic [31:0] m_mem [DEPTH];

  rv32i_instr_fetch #(
    .ADDR_W  (AW),
    .RESET_PC(32'h0000_0000),
    .CNT_W   (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .instr      (instr),
    .instr_valid(instr_valid),
    .halted     (halted),
    .err        (err),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_fpc = 32'h0; m_pc = 32'h0; m_pc4 = 32'h0;
    m_instr = NOP; m_valid = 1'b0; m_err = 1'b0; m_cnt = 0;
  endtask

  // One clock edge of the fetch stage as seen from outside.
  task automatic model_step();
    if (m_mode != 1) begin
      if (ld_en) m_mem[ld_addr] = ld_data;
      if (start) begin
        if (m_mode == 2) m_err = 1'b0;
        m_fpc = 32'h0; m_cnt = 0; m_mode = 1;
      end
    end else if (m_valid && m_instr == EBREAK) begin
      m_valid = 1'b0; m_mode = 2;
    end else if (redirect) begin
      m_fpc = redirect_pc - (redirect_pc % 4); m_valid = 1'b0;
    end else if (!stall) begin
      if (m_fpc >= 4 * DEPTH) begin
        m_err = 1'b1; m_valid = 1'b0; m_mode = 2;
      end else begin
        m_instr = m_mem[m_fpc / 4];
        m_pc = m_fpc; m_pc4 = m_fpc + 4; m_valid = 1'b1;
        m_fpc = m_fpc + 4;
        if (m_cnt < CMAX) m_cnt++;
      end
    end
  endtask

  task automatic compare_all();
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc4);
    check("instr", instr, m_instr);
    check("instr_valid", 32'(instr_valid), 32'(m_valid));
    check("halted", 32'(halted), 32'(m_mode == 2));
    check("err", 32'(err), 32'(m_err));
    check("fetch_count", 32'(fetch_count), m_cnt);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    cycle();
    ld_en = 1'b0;
  endtask

  logic [31:0] prog [6];

  initial begin
    prog[0] = 32'h0020_0113; prog[1] = 32'h0030_0193; prog[2] = 32'h0031_0233;
    prog[3] = 32'h4021_8233; prog[4] = 32'h0000_1697; prog[5] = 32'h0000_1737;
    rst_n = 1'b0; start = 0; stall = 0; redirect = 0; redirect_pc = 0;
    ld_en = 0; ld_addr = 0; ld_data = 0;
    model_reset();
    #12;
    check("rst_instr", instr, NOP);
    check("rst_valid", 32'(instr_valid), 32'h0);
    compare_all();
    @(negedge clk); rst_n = 1'b1;

    // Preload every word so the model and memory agree everywhere.
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] w;
      w = (i < 6) ? prog[i] : $urandom;
      if (w == EBREAK) w = NOP;
      load(AW'(i), w);
    end

    // Sequential fetch with a 3-cycle stall.
    start = 1; cycle(); start = 0;
    check("valid_after_start", 32'(instr_valid), 32'h0);
    cycle(); check("first_pc", pc, 32'h0); check("first_instr", instr, prog[0]);
    cycle(); check("second_pc", pc, 32'h4);
    cycle(); check("third_instr", instr, prog[2]); check("third_cnt", 32'(fetch_count), 3);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_instr", instr, prog[2]); check("stall_pc", pc, 32'h8);
      check("stall_cnt", 32'(fetch_count), 3);
    end
    stall = 0;
    cycle(); check("post_stall_instr", instr, prog[3]); check("post_stall_pc", pc, 32'hC);
    cycle(); cycle();
    check("sixth_pc", pc, 32'h14); check("sixth_plus4", pc_plus4, 32'h18);
    check("sixth_cnt", 32'(fetch_count), 6);

    // Redirect with stall on the same edge.
    redirect = 1; stall = 1; redirect_pc = 32'h8; cycle();
    redirect = 0; stall = 0;
    check("rs_bubble", 32'(instr_valid), 32'h0); check("rs_pc_hold", pc, 32'h14);
    cycle(); check("rs_pc", pc, 32'h8); check("rs_valid", 32'(instr_valid), 32'h1);

    // Out-of-range redirect halts with err after the bubble.
    redirect = 1; redirect_pc = 32'h400; cycle(); redirect = 0;
    check("oor_bubble", 32'(instr_valid), 32'h0); check("oor_not_halted", 32'(halted), 32'h0);
    cycle(); check("oor_halted", 32'(halted), 32'h1); check("oor_err", 32'(err), 32'h1);
    cycle();

    // ebreak at word 3.
    load(3, EBREAK);
    start = 1; cycle(); start = 0;
    check("restart_err", 32'(err), 32'h0); check("restart_cnt", 32'(fetch_count), 0);
    repeat (4) cycle();
    check("ebreak_pc", pc, 32'hC); check("ebreak_instr", instr, EBREAK);
    check("ebreak_valid", 32'(instr_valid), 32'h1);
    stall = 1; cycle(); stall = 0;
    check("ebreak_halt", 32'(halted), 32'h1); check("ebreak_err", 32'(err), 32'h0);

    // Misaligned redirect; a load during RUN must be ignored.
    load(3, prog[3]);
    start = 1; cycle(); start = 0;
    repeat (4) cycle();
    redirect = 1; redirect_pc = 32'h6; ld_en = 1; ld_addr = 1; ld_data = 32'hDEAD_BEEF;
    cycle();
    redirect = 0; ld_en = 0;
    check("align_bubble", 32'(instr_valid), 32'h0);
    cycle(); check("align_pc", pc, 32'h4); check("align_instr", instr, prog[1]);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      stall    = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 9) == 0);
      redirect_pc = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 4 * DEPTH - 1))
                                               : $urandom;
      start   = ($urandom_range(0, 19) == 0);
      ld_en   = ($urandom_range(0, 3) == 0);
      ld_addr = AW'($urandom);
      ld_data = ($urandom_range(0, 7) == 0) ? EBREAK : $urandom;
      cycle();
    end
    stall = 0; redirect = 0; ld_en = 0; start = 0;

    // Asynchronous reset in the middle of a run.
    if (m_mode == 1) cycle();
    else begin start = 1; cycle(); start = 0; end
    cycle(); cycle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_valid", 32'(instr_valid), 32'h0);
    check("async_rst_instr", instr, NOP);
    compare_all();
    #2 rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rv32i_instr_fetch.md
Name: rv32i_instr_fetch

Overview:
Instruction-fetch stage of the RV32I single-cycle core. It sits directly upstream of the instruction decoder, which consumes the 32-bit instruction word and produces the control bundle.
- Holds the program counter and a word-addressed instruction memory.
- Presents one registered instruction per cycle with its PC.
- Supports stall, redirect (branch/jal/jalr) and halt on ebreak or out-of-range PC.

Parameters:
ADDR_W, 8, log2 of instruction-memory depth in 32-bit words (256 words).
RESET_PC, 32'h0000_0000, PC loaded at reset and on start; must be word-aligned and in range.
CNT_W, 16, width of fetch_count.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  leave IDLE/HALT, begin fetching at RESET_PC.
stall  in  1  hold PC and outputs (decoder/back-end not ready).
redirect  in  1  take redirect_pc as next PC.
redirect_pc  in  32  branch/jump target from execute.
ld_en  in  1  instruction-memory write strobe (preload).
ld_addr  in  ADDR_W  word index for preload.
ld_data  in  32  instruction word for preload.
pc  out  32  PC of instr.
pc_plus4  out  32  pc + 4 (for jal/jalr link).
instr  out  32  fetched instruction, to decoder data_in.
instr_valid  out  1  instr/pc hold a real instruction.
halted  out  1  state is HALT.
err  out  1  halt caused by out-of-range PC.
fetch_count  out  CNT_W  valid instructions issued since start, saturating.

Behaviour:
- One clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: fetch_pc=RESET_PC, pc=0, pc_plus4=0, instr=32'h0000_0013 (nop), instr_valid=0, halted=0, err=0, fetch_count=0, state=IDLE. Memory contents are not reset.
- States:
  - IDLE: no fetch, instr_valid=0. When start=1: fetch_pc=RESET_PC, fetch_count=0, go to RUN.
  - RUN: fetch every cycle unless stalled; see below.
  - HALT: halted=1, instr_valid=0, outputs otherwise frozen. When start=1: clear err, fetch_pc=RESET_PC, fetch_count=0, go to RUN.
- Preload: ld_en writes mem[ld_addr]=ld_data at the clock edge, only in IDLE or HALT. In RUN, writes are ignored.
- RUN fetch (1-cycle latency, registered outputs). On each edge with stall=0 and redirect=0:
  - instr <= mem[fetch_pc[ADDR_W+1:2]]
  - pc <= fetch_pc; pc_plus4 <= fetch_pc+4
  - instr_valid <= 1; fetch_pc <= fetch_pc+4 (32-bit wrap)
  - fetch_count += 1, saturating at all-ones.
- stall=1, redirect=0: fetch_pc, instr, pc, pc_plus4, instr_valid and fetch_count all hold.
- redirect=1 (priority over stall):
  - fetch_pc <= {redirect_pc[31:2],2'b00} (low bits forced to zero).
  - instr_valid <= 0 for one bubble; instr, pc and fetch_count hold.
  - Fetching resumes at the new PC on the next cycle.
- Out of range: if fetch_pc[31:ADDR_W+2] != 0 when a fetch would occur (RUN, no stall, no redirect), no fetch is performed. Instead: err <= 1, instr_valid <= 0, go to HALT.
- ebreak: when the fetched word equals 32'h0010_0073, it is issued normally with instr_valid=1 and counted. On the next edge: instr_valid <= 0, go to HALT (stall or redirect on that edge are ignored).
- start while in RUN is ignored.
- Reset asserted mid-operation forces all reset values immediately, independent of clk.

Test Plan:
1. Preload mem[0..5] = 00200113, 00300193, 00310233, 40218233, 00001697, 00001737 in IDLE; pulse start. Required: instr follows that sequence on consecutive cycles with pc = 0, 4, 8, 0xC, 0x10, 0x14; pc_plus4 = pc+4; first instr_valid one cycle after start; fetch_count = 6 after the sixth word.
2. During the run, hold stall for 3 cycles while instr=00310233. Required: instr, pc=8 and fetch_count=3 frozen for the stall cycles; 40218233 issues on the first cycle after stall drops.
3. redirect=1 with redirect_pc=0x0000_0006 while fetch_pc=0x10. Required: next cycle instr_valid=0; following cycle pc=0x4 (aligned), instr=00300193.
4. redirect and stall both high on the same cycle. Required: redirect honored, one bubble, no hold of the old PC.
5. Place 00100073 at mem[3]. Required: it is issued with pc=0xC and instr_valid=1; next cycle halted=1, instr_valid=0, err=0; ld_en now writes mem; start restarts at pc=0 with fetch_count cleared.
6. redirect_pc=0x0000_0400 with ADDR_W=8. Required: after the bubble cycle, halted=1 and err=1, no valid instruction issued. Then assert rst_n=0 mid-run: all outputs return to reset values with no clock edge.
